// File: rtl/dither_pkg.sv
// Shared constants and elaboration helpers for the dither source.
// Tap masks are 32-bit; callers keep the low LFSR_W bits.
package dither_pkg;

  localparam logic MODE_RPDF = 1'b0;
  localparam logic MODE_TPDF = 1'b1;

  localparam logic [31:0] SEED_DEF = 32'h0000_ACE1;

  function automatic logic lfsr_w_legal(input int w);
    return (w == 8) || (w == 16) ||
           (w == 24) || (w == 32);
  endfunction

  function automatic logic out_w_legal(
    input int ow,
    input int lw
  );
    return (ow >= 1) && (ow <= lw / 2);
  endfunction

  // XNOR taps for maximal-length sequences
  function automatic logic [31:0] tap_mask(input int w);
    logic [31:0] m;
    m = 32'h0;
    unique case (1'b1)
      (w == 8):  m = 32'h0000_00B8;
      (w == 16): m = 32'h0000_D008;
      (w == 24): m = 32'h00E1_0000;
      (w == 32): m = 32'h8020_0003;
      default:   m = 32'h0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/lfsr_core.sv
// Fibonacci XNOR LFSR with seed load and all-ones lock-up guard.
// Load wins over step; an all-ones seed is replaced by SEED.
module lfsr_core
  import dither_pkg::*;
#(
  parameter int              LFSR_W = 16,
  parameter logic [LFSR_W-1:0] SEED =
    SEED_DEF[LFSR_W-1:0]
) (
  input  logic              iclk,
  input  logic              ireset,
  input  logic              istep,
  input  logic              iload,
  input  logic [LFSR_W-1:0] iseed,
  output logic [LFSR_W-1:0] ostate,
  output logic [LFSR_W-1:0] onext,
  output logic              olockup
);

  localparam logic [31:0] TAP32 = tap_mask(LFSR_W);
  localparam logic [LFSR_W-1:0] TAP =
    TAP32[LFSR_W-1:0];

  logic [LFSR_W-1:0] r_state;
  logic              r_lock;
  logic              w_fb;
  logic              w_ones;
  logic [LFSR_W-1:0] w_next;

  assign w_fb   = ~^(r_state & TAP);
  assign w_next = {r_state[LFSR_W-2:0], w_fb};
  assign w_ones = &iseed;

  always_ff @(posedge iclk) begin
    if (ireset) begin
      r_state <= SEED;
      r_lock  <= 1'b0;
    end else if (iload) begin
      r_state <= w_ones ? SEED : iseed;
      if (w_ones) r_lock <= 1'b1;
    end else if (istep) begin
      r_state <= w_next;
    end
  end

  assign ostate  = r_state;
  assign onext   = w_next;
  assign olockup = r_lock;

endmodule

// File: rtl/dither_gen.sv
// Parametrised RPDF/TPDF dither source for the NCO path.
// Output reflects the pre-step LFSR state, one cycle after the enabled edge.
module dither_gen
  import dither_pkg::*;
#(
  parameter int              LFSR_W = 16,
  parameter int              OUT_W  = 4,
  parameter logic [LFSR_W-1:0] SEED =
    SEED_DEF[LFSR_W-1:0]
) (
  input  logic              iclk,
  input  logic              ireset,
  input  logic              inCS,
  input  logic              iseed_load,
  input  logic [LFSR_W-1:0] iseed,
  input  logic              imode,
  output logic [OUT_W:0]    out,
  output logic              ovalid,
  output logic              owrap,
  output logic              olockup
);

  if (!lfsr_w_legal(LFSR_W)) begin : g_bad_lfsr_w
    $error("dither_gen: LFSR_W must be 8/16/24/32");
  end
  if (!out_w_legal(OUT_W, LFSR_W)) begin : g_bad_out_w
    $error("dither_gen: OUT_W out of range");
  end
  if (&SEED) begin : g_bad_seed
    $error("dither_gen: SEED must not be all-ones");
  end

  logic [LFSR_W-1:0] w_state;
  logic [LFSR_W-1:0] w_next;
  logic              w_step;
  logic [OUT_W-1:0]  w_top;
  logic [OUT_W-1:0]  w_bot;
  logic [OUT_W:0]    w_sum;
  logic [OUT_W:0]    w_word;

  logic [OUT_W:0]    r_out;
  logic              r_valid;
  logic              r_wrap;

  assign w_step = ~inCS & ~iseed_load;

  lfsr_core #(
    .LFSR_W (LFSR_W),
    .SEED   (SEED)
  ) u_core (
    .iclk    (iclk),
    .ireset  (ireset),
    .istep   (w_step),
    .iload   (iseed_load),
    .iseed   (iseed),
    .ostate  (w_state),
    .onext   (w_next),
    .olockup (olockup)
  );

  // TPDF fields are disjoint because OUT_W <= LFSR_W/2
  assign w_top  = w_state[LFSR_W-1 -: OUT_W];
  assign w_bot  = w_state[OUT_W-1:0];
  assign w_sum  = {1'b0, w_top} + {1'b0, w_bot};
  assign w_word = (imode == MODE_TPDF) ?
                  w_sum : {1'b0, w_top};

  always_ff @(posedge iclk) begin
    if (ireset) begin
      r_out   <= '0;
      r_valid <= 1'b0;
      r_wrap  <= 1'b0;
    end else if (w_step) begin
      r_out   <= w_word;
      r_valid <= 1'b1;
      r_wrap  <= (w_next == SEED);
    end else begin
      r_valid <= 1'b0;
      r_wrap  <= 1'b0;
    end
  end

  assign out    = r_out;
  assign ovalid = r_valid;
  assign owrap  = r_wrap;

endmodule

// File: tb/tb_dither_gen.sv
// Self-checking bench: vector table plus scoreboarded period and width runs.
// Valid outputs are checked against a queue by a negedge monitor.
module tb_dither_gen;

  logic        clk;
  logic        rst;

  logic        cs8, ld8, md8;
  logic [7:0]  sd8;
  logic [4:0]  out8;
  logic        vld8, wrp8, lck8;

  logic        cs32, ld32, md32;
  logic [31:0] sd32;
  logic [16:0] out32;
  logic        vld32, wrp32, lck32;

  int n_cmp;
  int n_bad;

  logic [63:0] q8[$];
  logic [63:0] q32[$];

  dither_gen #(
    .LFSR_W (8),
    .OUT_W  (4),
    .SEED   (8'hAA)
  ) u8 (
    .iclk       (clk),
    .ireset     (rst),
    .inCS       (cs8),
    .iseed_load (ld8),
    .iseed      (sd8),
    .imode      (md8),
    .out        (out8),
    .ovalid     (vld8),
    .owrap      (wrp8),
    .olockup    (lck8)
  );

  dither_gen #(
    .LFSR_W (32),
    .OUT_W  (16)
  ) u32 (
    .iclk       (clk),
    .ireset     (rst),
    .inCS       (cs32),
    .iseed_load (ld32),
    .iseed      (sd32),
    .imode      (md32),
    .out        (out32),
    .ovalid     (vld32),
    .owrap      (wrp32),
    .olockup    (lck32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       nm,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h",
               nm, act, exp);
    end
  endtask

  // Reference LFSR from the 1-indexed tap list
  function automatic logic [31:0] mdl_next(
    input int          w,
    input logic [31:0] s
  );
    int          t[4];
    logic        fb;
    logic [63:0] m;
    logic [63:0] n;
    case (w)
      8:       t = '{8, 6, 5, 4};
      16:      t = '{16, 15, 13, 4};
      24:      t = '{24, 23, 22, 17};
      default: t = '{32, 22, 2, 1};
    endcase
    fb = 1'b1;
    for (int i = 0; i < 4; i++)
      fb = fb ^ s[t[i]-1];
    m = (64'd1 << w) - 64'd1;
    n = ({32'h0, s} << 1) | {63'h0, fb};
    return 32'(n & m);
  endfunction

  always @(negedge clk) begin
    if (vld8) begin
      if (q8.size() == 0) begin
        chk("out8_unexpected_valid", 64'd1, 64'd0);
      end else begin
        chk("out8", 64'(out8), q8.pop_front());
      end
    end
    if (vld32) begin
      if (q32.size() == 0) begin
        chk("out32_unexpected_valid", 64'd1, 64'd0);
      end else begin
        chk("out32", 64'(out32), q32.pop_front());
      end
    end
  end

  typedef struct {
    logic       rst;
    logic       cs_n;
    logic       ld;
    logic       mode;
    logic [7:0] seed;
    logic [7:0] lfsr;
    logic [4:0] dout;
    logic       vld;
    logic       wrp;
    logic       lck;
  } vec_t;

  vec_t vt[19];

  logic [31:0] s;
  logic [31:0] ns;
  logic [63:0] ex;
  bit          seen[256];
  int          wraps;
  int          first_wrap;
  int          reps;
  int          ones;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    cs8 = 1'b1; ld8 = 1'b0; md8 = 1'b0; sd8 = '0;
    cs32 = 1'b1; ld32 = 1'b0; md32 = 1'b0; sd32 = '0;

    //        rst cs ld md seed   lfsr   out    v  w  l
    vt[0]  = '{1, 1, 0, 0, 8'h00, 8'hAA, 5'h00, 0, 0, 0};
    vt[1]  = '{0, 0, 0, 0, 8'h00, 8'h54, 5'h0A, 1, 0, 0};
    vt[2]  = '{0, 0, 0, 0, 8'h00, 8'hA8, 5'h05, 1, 0, 0};
    vt[3]  = '{0, 0, 0, 0, 8'h00, 8'h50, 5'h0A, 1, 0, 0};
    vt[4]  = '{1, 0, 0, 1, 8'h00, 8'hAA, 5'h00, 0, 0, 0};
    vt[5]  = '{0, 0, 0, 1, 8'h00, 8'h54, 5'h14, 1, 0, 0};
    vt[6]  = '{0, 0, 0, 1, 8'h00, 8'hA8, 5'h09, 1, 0, 0};
    vt[7]  = '{0, 1, 0, 1, 8'h00, 8'hA8, 5'h09, 0, 0, 0};
    vt[8]  = '{0, 1, 0, 0, 8'h00, 8'hA8, 5'h09, 0, 0, 0};
    vt[9]  = '{0, 0, 0, 0, 8'h00, 8'h50, 5'h0A, 1, 0, 0};
    vt[10] = '{0, 0, 1, 0, 8'hFF, 8'hAA, 5'h0A, 0, 0, 1};
    vt[11] = '{0, 0, 0, 0, 8'h00, 8'h54, 5'h0A, 1, 0, 1};
    vt[12] = '{0, 1, 1, 0, 8'h3C, 8'h3C, 5'h0A, 0, 0, 1};
    vt[13] = '{0, 0, 0, 1, 8'h00, 8'h78, 5'h0F, 1, 0, 1};
    vt[14] = '{1, 0, 1, 0, 8'hFF, 8'hAA, 5'h00, 0, 0, 0};
    vt[15] = '{0, 0, 0, 0, 8'h00, 8'h54, 5'h0A, 1, 0, 0};
    vt[16] = '{1, 0, 0, 0, 8'h00, 8'hAA, 5'h00, 0, 0, 0};
    vt[17] = '{0, 0, 0, 0, 8'h00, 8'h54, 5'h0A, 1, 0, 0};
    vt[18] = '{0, 0, 1, 0, 8'hAA, 8'hAA, 5'h0A, 0, 0, 0};

    for (int i = 0; i < 19; i++) begin
      rst = vt[i].rst;
      cs8 = vt[i].cs_n;
      ld8 = vt[i].ld;
      md8 = vt[i].mode;
      sd8 = vt[i].seed;
      if (vt[i].vld) q8.push_back(64'(vt[i].dout));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_lfsr", i),
          64'(u8.w_state), 64'(vt[i].lfsr));
      chk($sformatf("v%0d_valid", i),
          64'(vld8), 64'(vt[i].vld));
      chk($sformatf("v%0d_wrap", i),
          64'(wrp8), 64'(vt[i].wrp));
      chk($sformatf("v%0d_lockup", i),
          64'(lck8), 64'(vt[i].lck));
      if (!vt[i].vld)
        chk($sformatf("v%0d_out_hold", i),
            64'(out8), 64'(vt[i].dout));
    end

    // Full-period walk at LFSR_W=8
    rst = 1'b1; cs8 = 1'b1; ld8 = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    s = 32'hAA;
    for (int i = 0; i < 256; i++) seen[i] = 1'b0;
    seen[8'hAA] = 1'b1;
    wraps = 0; first_wrap = 0; reps = 0; ones = 0;
    for (int k = 1; k <= 256; k++) begin
      cs8 = 1'b0;
      md8 = k[0];
      if (md8)
        ex = 64'({1'b0, s[7:4]} + {1'b0, s[3:0]});
      else
        ex = 64'(s[7:4]);
      q8.push_back(ex);
      ns = mdl_next(8, s);
      @(posedge clk);
      #1;
      chk($sformatf("p%0d_lfsr", k),
          64'(u8.w_state), 64'(ns));
      chk($sformatf("p%0d_wrap", k),
          64'(wrp8), 64'(ns == 32'hAA));
      if (wrp8) begin
        wraps++;
        if (first_wrap == 0) first_wrap = k;
      end
      if (u8.w_state == 8'hFF) ones++;
      if (k < 255 && seen[u8.w_state]) reps++;
      seen[u8.w_state] = 1'b1;
      s = ns;
    end
    cs8 = 1'b1;
    chk("period_wrap_count", 64'(wraps), 64'd1);
    chk("period_first_wrap", 64'(first_wrap), 64'd255);
    chk("period_repeats", 64'(reps), 64'd0);
    chk("period_all_ones", 64'(ones), 64'd0);

    // Width coverage at LFSR_W=32, OUT_W=16
    rst = 1'b1; cs32 = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("w32_reset_lfsr", 64'(u32.w_state), 64'h0000ACE1);
    chk("w32_reset_out", 64'(out32), 64'd0);
    s = 32'h0000ACE1;
    for (int k = 0; k < 40; k++) begin
      cs32 = 1'b0;
      md32 = (k >= 20) ? k[0] : 1'b0;
      if (md32)
        ex = 64'({1'b0, s[31:16]} + {1'b0, s[15:0]});
      else
        ex = 64'(s[31:16]);
      q32.push_back(ex);
      ns = mdl_next(32, s);
      @(posedge clk);
      #1;
      chk($sformatf("w32_%0d_lfsr", k),
          64'(u32.w_state), 64'(ns));
      s = ns;
    end
    cs32 = 1'b1;
    @(posedge clk);
    #1;
    chk("w32_idle_valid", 64'(vld32), 64'd0);
    chk("w32_lockup", 64'(lck32), 64'd0);

    repeat (2) @(posedge clk);
    #1;
    chk("q8_drained", 64'(q8.size()), 64'd0);
    chk("q32_drained", 64'(q32.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dither_gen.md
Name: dither_gen

Overview:
Parametrised pseudo-random dither source for the NCO phase/amplitude path. It is the successor of the fixed 8-bit, 4-bit-output dither generator. New in this generation:
- LFSR width and output width are parameters.
- Selectable rectangular (RPDF) or triangular (TPDF) distribution.
- Runtime seed load with lock-up protection.
- Output-valid and period-wrap indications.

It sits beside the phase accumulator and is advanced by the same active-low chip-select strobe.

Parameters:
LFSR_W, 16, LFSR length. Legal values are 8, 16, 24 and 32; any other value is an elaboration error.
OUT_W, 4, dither word width. Range 1..LFSR_W/2 (the bound guarantees disjoint TPDF fields).
SEED, 'hACE1 (truncated to LFSR_W), reset/default LFSR state. Must not be all-ones (elaboration error).

Ports:
iclk  in  1  clock
ireset  in  1  synchronous active-high reset
inCS  in  1  active-low advance enable; LFSR steps and output updates only when 0
iseed_load  in  1  load iseed into LFSR (registered, one cycle)
iseed  in  LFSR_W  runtime seed value
imode  in  1  0 = RPDF, 1 = TPDF
out  out  OUT_W+1  dither word, unsigned
ovalid  out  1  out updated this cycle
owrap  out  1  one-cycle pulse when LFSR state returns to SEED after a step
olockup  out  1  sticky: an all-ones seed was rejected

Behaviour:
- Clocking and reset:
  - One clock: iclk.
  - Reset is synchronous and active-high on ireset.
  - Reset values: lfsr=SEED, out=0, ovalid=0, owrap=0, olockup=0.
  - ireset has priority over every other input.
  - Reset mid-sequence discards state; the sequence restarts from SEED.
- LFSR:
  - Fibonacci form, shifts toward the MSB: lfsr <= {lfsr[LFSR_W-2:0], fb}.
  - fb = XNOR of tap bits (1-indexed): 8: 8,6,5,4; 16: 16,15,13,4; 24: 24,23,22,17; 32: 32,22,2,1.
  - Period is maximal: 2^LFSR_W-1. The lock-up state is all-ones.
- Priority per cycle (after reset): iseed_load > step (inCS==0) > hold.
- Seed load:
  - lfsr <= iseed. If iseed is all-ones, lfsr <= SEED instead and olockup <= 1; olockup stays set until reset.
  - Output registers are not updated in a load cycle: ovalid=0, out holds.
  - A load takes priority even when inCS==0; no step occurs that cycle.
- Step cycle (inCS==0, no load):
  - Output is computed from the pre-step LFSR state (current value S), i.e. one cycle of latency from the enabled edge.
  - RPDF: out <= {1'b0, S[LFSR_W-1 -: OUT_W]}.
  - TPDF: out <= S[LFSR_W-1 -: OUT_W] + S[OUT_W-1:0], full OUT_W+1-bit sum, no wrap or saturation.
  - ovalid <= 1.
  - owrap <= 1 if next state == SEED, else 0.
- Idle cycle (inCS==1, no load): lfsr and out hold; ovalid <= 0; owrap <= 0.
- imode is sampled on each step cycle. A mode change affects only the next out update and never disturbs the LFSR.
- owrap is driven only by stepping. Loading SEED via iseed_load does not pulse owrap.

Decomposition:
- Package dither_pkg holds:
  - function tap_mask(width) returning the LFSR_W-bit tap mask;
  - constants MODE_RPDF=0 and MODE_TPDF=1;
  - legal-width checks.
- Sub-module lfsr_core (parameters LFSR_W, SEED; ports iclk, ireset, istep, iload, iseed, ostate, onext, olockup) owns state, feedback, load and the lock-up guard.
- dither_gen contains lfsr_core plus the output/mode/valid/wrap register stage.

Test Plan:
- Reset with LFSR_W=8, OUT_W=4, SEED=8'hAA, then hold inCS=0 for three cycles, imode=0 -> out = 0x0A, 0x05, 0x0A on successive cycles; lfsr = 0x54, 0xA8; ovalid=1 from the first post-enable edge.
- Same sequence with imode=1 -> out = 0x14 (A+A), then 0x09 (5+4); ovalid=1.
- LFSR_W=8, step continuously from SEED -> owrap pulses exactly once per 255 steps (first at step 255); no state repeats within the period; state is never 0xFF.
- iseed_load=1 with iseed=8'hFF while inCS=0 -> lfsr=SEED (0xAA), olockup=1 until reset, ovalid=0 and out unchanged that cycle; next step proceeds from 0xAA.
- inCS toggled 0,1,1,0 -> LFSR and out hold during inCS=1; ovalid pattern 1,0,0,1; no owrap during idle.
- ireset asserted mid-run at state 0x54 -> next cycle lfsr=0xAA, out=0, ovalid=0, olockup=0; repeat the RPDF check at LFSR_W=32, OUT_W=16 for width coverage.
